instr_encoder: RTL



---
 rtl/instr_encoder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Encodes RV32I R-type / I-type ALU requests into instruction words and
// streams them out of a small FIFO.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [3:0]                 req_op_i,
    input  logic [4:0]                 req_rd_i,
    input  logic [4:0]                 req_rs1_i,
    input  logic [4:0]                 req_rs2_i,
    input  logic [11:0]                req_imm_i,
    output logic                       instr_valid_o,
    input  logic                       instr_ready_i,
    output logic [31:0]                instr_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       err_o,
    output logic [CNT_W-1:0]           issued_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    // Both interfaces: a transfer happens on a rising edge where valid and
    // ready are both high; ready never depends on valid in the same cycle.

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          err_q;
    logic [CNT_W-1:0] issued;

    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_r;
    logic        is_shift;
    logic        illegal;
    logic [31:0] word;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        funct3   = 3'b000;
        funct7   = 7'b0000000;
        is_r     = 1'b0;
        is_shift = 1'b0;
        case (req_op_i)
            4'd0:  begin is_r = 1'b1; funct3 = 3'b000; end
            4'd1:  begin is_r = 1'b1; funct3 = 3'b000; funct7 = F7_ALT; end
            4'd2:  begin is_r = 1'b1; funct3 = 3'b001; end
            4'd3:  begin is_r = 1'b1; funct3 = 3'b010; end
            4'd4:  begin is_r = 1'b1; funct3 = 3'b100; end
            4'd5:  begin is_r = 1'b1; funct3 = 3'b101; end
            4'd6:  begin is_r = 1'b1; funct3 = 3'b101; funct7 = F7_ALT; end
            4'd7:  begin is_r = 1'b1; funct3 = 3'b110; end
            4'd8:  begin is_r = 1'b1; funct3 = 3'b111; end
            4'd9:  funct3 = 3'b000;
            4'd10: funct3 = 3'b100;
            4'd11: funct3 = 3'b110;
            4'd12: funct3 = 3'b111;
            4'd13: begin is_shift = 1'b1; funct3 = 3'b001; end
            4'd14: begin is_shift = 1'b1; funct3 = 3'b101; end
            default: begin is_shift = 1'b1; funct3 = 3'b101; funct7 = F7_ALT; end
        endcase
    end

    always_comb begin
        if (is_r) begin
            word = {funct7, req_rs2_i, req_rs1_i, funct3, req_rd_i, OPC_R};
        end else if (is_shift) begin
            word = {funct7, req_imm_i[4:0], req_rs1_i, funct3, req_rd_i, OPC_I};
        end else begin
            word = {req_imm_i, req_rs1_i, funct3, req_rd_i, OPC_I};
        end
    end

    // Shift amounts above 31 cannot be encoded; such requests are consumed
    // and reported rather than stalled.
    assign illegal     = is_shift && (req_imm_i[11:5] != 7'd0);
    assign req_ready_o = (count < FULL);
    assign accept      = req_valid_i && req_ready_o;
    assign push        = accept && !illegal;
    assign pop         = instr_valid_o && instr_ready_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
            issued <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                issued <= issued + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            err_q <= accept && illegal;
        end
    end

    assign instr_valid_o = (count != '0);
    assign instr_o       = instr_valid_o ? mem[rd_ptr] : NOP;
    assign count_o       = count;
    assign err_o         = err_q;
    assign issued_cnt_o  = issued;

endmodule
